// File: rtl/jt51_wrseq_if.sv
// Host write-request and sound-core register-port signals for jt51_wrseq.
interface jt51_wrseq_if;
  logic       req_valid;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready;
  logic       ym_busy;
  logic       ym_cs_n;
  logic       ym_wr_n;
  logic       ym_a0;
  logic [7:0] ym_din;
  logic       idle;

  modport master (
    output req_valid, req_addr, req_data, ym_busy,
    input  req_ready, ym_cs_n, ym_wr_n, ym_a0, ym_din, idle
  );

  modport slave (
    input  req_valid, req_addr, req_data, ym_busy,
    output req_ready, ym_cs_n, ym_wr_n, ym_a0, ym_din, idle
  );
endinterface

// File: rtl/jt51_wrseq.sv
// Queues host register writes and replays them to the JT51 core as address/data
// strobe pairs, one cen period each, with a busy-blind settle window after each pair.
module jt51_wrseq #(
  parameter int DEPTH     = 4,
  parameter int BUSY_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  jt51_wrseq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT + 1) : 1;

  // IDLE: wait for entry and !busy | ADDR: a0=0 strobe | DATA: a0=1 strobe, pop | WAIT: busy ignored
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          cs_n_q, cs_n_d;
  logic          wr_n_q, wr_n_d;
  logic          a0_q, a0_d;
  logic [7:0]    din_q, din_d;
  logic          idle_q, idle_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   wdata_d;
  logic [15:0]   head;
  logic          ready;
  logic          push;
  logic          pop;

  assign ready   = (count_q != CW'(DEPTH));
  assign push    = bus.req_valid && ready;
  assign wdata_d = {bus.req_addr, bus.req_data};
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    a0_d    = a0_q;
    din_d   = din_q;
    pop     = 1'b0;
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0 && !bus.ym_busy) begin
            state_d = S_ADDR;
            cs_n_d  = 1'b0;
            wr_n_d  = 1'b0;
            a0_d    = 1'b0;
            din_d   = head[15:8];
          end
        end
        S_ADDR: begin
          state_d = S_DATA;
          a0_d    = 1'b1;
          din_d   = head[7:0];
          pop     = 1'b1;
        end
        S_DATA: begin
          state_d = S_WAIT;
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          wait_d  = WW'(BUSY_WAIT);
        end
        S_WAIT: begin
          // Leave on the edge that takes the counter to zero (or if it already is).
          if (wait_q <= WW'(1)) begin
            state_d = S_IDLE;
            wait_d  = '0;
          end else begin
            wait_d  = wait_q - WW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    idle_d = (count_d == '0) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wait_q   <= '0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a0_q     <= 1'b0;
      din_q    <= 8'h00;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wait_q   <= wait_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      a0_q     <= a0_d;
      din_q    <= din_d;
      idle_q   <= idle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_d;
  end

  assign bus.req_ready = ready;
  assign bus.ym_cs_n   = cs_n_q;
  assign bus.ym_wr_n   = wr_n_q;
  assign bus.ym_a0     = a0_q;
  assign bus.ym_din    = din_q;
  assign bus.idle      = idle_q;
endmodule

// File: tb/tb_jt51_wrseq.sv
// Bench for jt51_wrseq: transaction scoreboard with gap-rule timing model, directed
// corner sequences and a randomized soak.
module tb_jt51_wrseq;
  localparam int DEPTH = 4;
  localparam int BW    = 2;
  localparam int NEED  = ((BW > 1) ? BW : 1) + 1;  // deasserted cen ticks before a new write may start
  localparam int PH_N = 0, PH_A = 1, PH_D = 2, PH_X = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cen_auto = 1'b0;
  logic cen_man = 1'b0;
  int   cen_mode = 0;
  logic cen;
  assign cen = (cen_mode == 2) ? cen_man : cen_auto;

  jt51_wrseq_if bus();

  jt51_wrseq #(.DEPTH(DEPTH), .BUSY_WAIT(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cen_mode == 0)      cen_auto = ~cen_auto;
    else if (cen_mode == 1) cen_auto = ($urandom_range(2) != 0);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted entries in order, count, and strobe-phase history.
  logic [15:0] mq[$];
  logic [15:0] wlog[$];
  int          m_cnt = 0;
  int          last = PH_N;
  int          since = 100;
  logic        hold_a0 = 1'b0;
  logic [7:0]  hold_din = 8'h00;
  logic [7:0]  a_din = 8'h00;
  logic        p_cs = 1'b1, p_wr = 1'b1, p_a0 = 1'b0;
  logic [7:0]  p_din = 8'h00;

  always @(posedge clk) begin : mon
    logic        v, b, c, acc, pop;
    logic [15:0] e;
    int          pre, obs, expph;
    v = bus.req_valid; e = {bus.req_addr, bus.req_data}; b = bus.ym_busy; c = cen; pre = m_cnt;
    #1;
    if (!rst_n) begin
      mq.delete(); m_cnt = 0; last = PH_N; since = 100;
      hold_a0 = 1'b0; hold_din = 8'h00;
      p_cs = 1'b1; p_wr = 1'b1; p_a0 = 1'b0; p_din = 8'h00;
    end else begin
      pop = 1'b0;
      acc = v && (pre != DEPTH);
      if (c) begin
        if (!bus.ym_cs_n && !bus.ym_wr_n) obs = bus.ym_a0 ? PH_D : PH_A;
        else if (bus.ym_cs_n && bus.ym_wr_n) obs = PH_N;
        else obs = PH_X;
        if (last == PH_A)      expph = PH_D;
        else if (last == PH_D) expph = PH_N;
        else expph = (since >= NEED && pre > 0 && !b) ? PH_A : PH_N;
        chk("phase", obs, expph);
        if (obs == PH_A && expph == PH_A) begin
          chk("addr_byte", bus.ym_din, mq[0][15:8]);
          a_din = bus.ym_din;
        end else if (obs == PH_D && expph == PH_D) begin
          chk("data_byte", bus.ym_din, mq[0][7:0]);
          wlog.push_back({a_din, bus.ym_din});
          if (mq.size() > 0) begin
            void'(mq.pop_front());
            pop = 1'b1;
          end
          hold_a0 = 1'b1; hold_din = bus.ym_din;
        end else if (obs == PH_N) begin
          chk("hold_a0_din", {bus.ym_a0, bus.ym_din}, {hold_a0, hold_din});
        end
        since = (obs == PH_N) ? ((since < 100) ? since + 1 : 100) : 0;
        last = obs;
      end else begin
        chk("freeze", {bus.ym_cs_n, bus.ym_wr_n, bus.ym_a0, bus.ym_din}, {p_cs, p_wr, p_a0, p_din});
      end
      if (acc) mq.push_back(e);
      m_cnt = pre + (acc ? 1 : 0) - (pop ? 1 : 0);
      chk("req_ready", bus.req_ready, (m_cnt != DEPTH));
      chk("idle", bus.idle, (m_cnt == 0 && last == PH_N && since >= NEED));
      p_cs = bus.ym_cs_n; p_wr = bus.ym_wr_n; p_a0 = bus.ym_a0; p_din = bus.ym_din;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_wait", (n < 400), 1);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.idle && m_cnt == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 2000), 1);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_idle;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t        tv[5];
    int          n, na, nd, ni, gap, accd, base;
    logic [7:0]  a, d;
    logic [15:0] exp9[9];

    tv[0] = '{8'h01, 8'h11, 1'b1, 1'b0};
    tv[1] = '{8'h02, 8'h22, 1'b1, 1'b0};
    tv[2] = '{8'h03, 8'h33, 1'b1, 1'b0};
    tv[3] = '{8'h04, 8'h44, 1'b0, 1'b0};
    tv[4] = '{8'h05, 8'h55, 1'b0, 1'b0};

    bus.req_valid = 1'b0; bus.req_addr = 8'h00; bus.req_data = 8'h00; bus.ym_busy = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs_n", bus.ym_cs_n, 1);
    chk("rst_wr_n", bus.ym_wr_n, 1);
    chk("rst_a0", bus.ym_a0, 0);
    chk("rst_din", bus.ym_din, 0);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_idle", bus.idle, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single write timing with cen every 2nd clk
    push(8'h20, 8'hC7);
    n = 0;
    while (bus.ym_cs_n && n < 100) begin @(negedge clk); n++; end
    chk("w1_start", (n < 100), 1);
    a = bus.ym_din; na = 0;
    while (!bus.ym_cs_n && !bus.ym_a0 && na < 10) begin na++; @(negedge clk); end
    d = bus.ym_din; nd = 0;
    while (!bus.ym_cs_n && bus.ym_a0 && nd < 10) begin nd++; @(negedge clk); end
    ni = 0;
    while (!bus.idle && ni < 50) begin ni++; @(negedge clk); end
    chk("w1_addr_clks", na, 2);
    chk("w1_data_clks", nd, 2);
    chk("w1_addr", a, 8'h20);
    chk("w1_data", d, 8'hC7);
    chk("w1_gap_to_idle", ni, 4);

    // Fill while busy: table of pushes with expected ready/idle
    @(negedge clk); bus.ym_busy = 1'b1;
    repeat (2) @(negedge clk);
    base = wlog.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = tv[i].addr; bus.req_data = tv[i].data;
      @(posedge clk); #1;
      chk("tbl_ready", bus.req_ready, tv[i].exp_ready);
      chk("tbl_idle", bus.idle, tv[i].exp_idle);
    end
    @(negedge clk); bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("tbl_no_write_busy", wlog.size() - base, 0);
    bus.ym_busy = 1'b0;
    drain("tbl_drain");
    chk("tbl_count", wlog.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < wlog.size()) chk("tbl_order", wlog[base + i], {tv[i].addr, tv[i].data});

    // Long busy hold, then prompt start
    bus.ym_busy = 1'b1;
    push(8'h33, 8'h3C);
    n = 0;
    repeat (20) begin @(negedge clk); if (!bus.ym_cs_n) n++; end
    chk("busy_hold_nostrobe", n, 0);
    bus.ym_busy = 1'b0; n = 0;
    while (bus.ym_cs_n && n < 20) begin @(negedge clk); n++; end
    chk("busy_release_lat", (n >= 1 && n <= 2), 1);
    drain("busy_drain");

    // Busy pulse inside WAIT is ignored
    push(8'h41, 8'h14);
    push(8'h42, 8'h24);
    n = 0;
    while (!(!bus.ym_cs_n && bus.ym_a0) && n < 100) begin @(negedge clk); n++; end
    while (!bus.ym_cs_n && bus.ym_a0 && n < 200) begin @(negedge clk); n++; end
    gap = 1; bus.ym_busy = 1'b1;
    while (bus.ym_cs_n && gap < 50) begin
      @(negedge clk);
      if (bus.ym_cs_n) gap++;
      if (gap == 3) bus.ym_busy = 1'b0;
    end
    bus.ym_busy = 1'b0;
    chk("wait_busy_gap", gap, 6);
    drain("wait_drain");

    // Same-edge push and pop at count=2, manual cen
    cen_mode = 2; cen_man = 1'b0;
    @(negedge clk); bus.ym_busy = 1'b1;
    base = wlog.size();
    push(8'h61, 8'hA1);
    push(8'h62, 8'hA2);
    bus.ym_busy = 1'b0; cen_man = 1'b1;
    @(negedge clk); cen_man = 1'b0;
    chk("pp_in_addr", {bus.ym_cs_n, bus.ym_a0}, 2'b00);
    cen_man = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = 8'h63; bus.req_data = 8'hA3;
    @(negedge clk);
    cen_man = 1'b0; bus.req_valid = 1'b0; bus.ym_busy = 1'b1;
    chk("pp_in_data", {bus.ym_cs_n, bus.ym_a0}, 2'b01);
    accd = 0;
    while (bus.req_ready && accd < 6) begin
      bus.req_valid = 1'b1; bus.req_addr = 8'h64 + 8'(accd); bus.req_data = 8'hA4 + 8'(accd);
      @(negedge clk);
      accd++;
    end
    bus.req_valid = 1'b0;
    chk("pp_room_left", accd, 2);
    bus.ym_busy = 1'b0; cen_mode = 0;
    drain("pp_drain");
    chk("pp_count", wlog.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < wlog.size()) chk("pp_order", wlog[base + i], {8'h61 + 8'(i), 8'hA1 + 8'(i)});

    // Nine consecutive writes wrap both pointers
    base = wlog.size();
    for (int i = 0; i < 9; i++) begin
      a = 8'h80 + 8'(i); d = 8'($urandom);
      exp9[i] = {a, d};
      push(a, d);
    end
    drain("wrap_drain");
    chk("wrap_count", wlog.size() - base, 9);
    for (int i = 0; i < 9; i++)
      if (base + i < wlog.size()) chk("wrap_order", wlog[base + i], exp9[i]);

    // Reset during DATA with two entries queued
    bus.ym_busy = 1'b1;
    push(8'h91, 8'h19);
    push(8'h92, 8'h29);
    push(8'h93, 8'h39);
    bus.ym_busy = 1'b0; n = 0;
    while (!(!bus.ym_cs_n && bus.ym_a0) && n < 100) begin @(negedge clk); n++; end
    chk("rst_mid_reached_data", (n < 100), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", bus.ym_cs_n, 1);
    chk("rst_mid_wr_n", bus.ym_wr_n, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_ready", bus.req_ready, 1);
    chk("rst_mid_idle", bus.idle, 1);
    n = 0;
    repeat (40) begin @(negedge clk); if (!bus.ym_cs_n) n++; end
    chk("rst_mid_nowrite", n, 0);
    chk("rst_mid_idle_after", bus.idle, 1);

    // Randomized soak against the scoreboard
    cen_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.req_valid = ($urandom_range(2) != 0);
      bus.req_addr  = 8'($urandom);
      bus.req_data  = 8'($urandom);
      bus.ym_busy   = ($urandom_range(5) == 0);
    end
    bus.req_valid = 1'b0; bus.ym_busy = 1'b0; cen_mode = 0;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jt51_wrseq.md
JT51_WRSEQ -- requirements
Module: jt51_wrseq

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter: BUSY_WAIT, default 2, cen ticks after a data strobe during which ym_busy is ignored.
REQ-003 clk  in  1  main clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low, released synchronously to clk.
REQ-005 cen  in  1  clock enable; same enable that drives the sound core register interface (cen_p1 domain).
REQ-006 req_valid  in  1  host write request present.
REQ-007 req_addr  in  8  YM register address.
REQ-008 req_data  in  8  YM register data.
REQ-009 req_ready  out  1  FIFO can accept a request; equals (count != DEPTH).
REQ-010 ym_busy  in  1  busy bit from sound core status (dout bit 7).
REQ-011 ym_cs_n, ym_wr_n  out  1 each  active-low chip select and write to sound core.
REQ-012 ym_a0  out  1  0 = address port, 1 = data port.
REQ-013 ym_din  out  8  byte written to sound core.
REQ-014 idle  out  1  high when FIFO empty and FSM in IDLE.

Function
REQ-015 Push: req_valid && req_ready at a clk edge stores {req_addr, req_data}; cen is not required for push.
REQ-016 FIFO: circular, write/read pointers wrap DEPTH-1 -> 0; count has width log2(DEPTH)+1; push and pop on the same edge leave count unchanged.
REQ-017 Push while full is ignored; stored entries and count are unchanged.
REQ-018 FSM states: IDLE, ADDR, DATA, WAIT; transitions occur only on edges where cen=1.
REQ-019 IDLE -> ADDR when count != 0 and ym_busy=0; outputs on the next edge: cs_n=0, wr_n=0, a0=0, din=head addr.
REQ-020 ADDR -> DATA on the next cen edge; outputs: cs_n=0, wr_n=0, a0=1, din=head data; the head entry is popped on this edge.
REQ-021 DATA -> WAIT on the next cen edge; outputs: cs_n=1, wr_n=1; a0 and din hold; wait counter loads BUSY_WAIT.
REQ-022 WAIT: the counter decrements on each cen edge, and ym_busy is not examined; at zero -> IDLE; with BUSY_WAIT=0, WAIT exits on its first cen edge.
REQ-023 Each strobe is therefore exactly one cen period long; consecutive writes are separated by at least BUSY_WAIT+1 cen periods with strobes deasserted.
REQ-024 IDLE with ym_busy=1 holds IDLE, strobes deasserted, no pop.
REQ-025 Pushes during ADDR, DATA or WAIT are queued; the entry being written is never overwritten, because the pop occurs only at ADDR -> DATA.
REQ-026 cen=0 freezes the FSM, wait counter and all ym_* outputs; FIFO pushes continue.
REQ-027 All ym_* outputs and idle are registered, with no combinational path from inputs; req_ready derives only from registered count.
REQ-028 Writes are issued in push order; no reordering or merging of writes to the same address.

Reset
REQ-029 While rst_n=0: state=IDLE, count=0, pointers=0, wait counter=0, ym_cs_n=1, ym_wr_n=1, ym_a0=0, ym_din=0, req_ready=1, idle=1.
REQ-030 Reset asserted mid-write (ADDR/DATA) immediately deasserts strobes; the queued entries and the in-flight write are discarded.

Verification
REQ-031 cen every 2nd clk, BUSY_WAIT=2, push (0x20,0xC7), ym_busy=0 -> one cen period with a0=0, din=0x20, then one with a0=1, din=0xC7, then 2 cen periods idle, idle=1.
REQ-032 Push 4 entries (DEPTH=4) back-to-back while ym_busy=1 -> req_ready=0 after the 4th; a 5th push is dropped; release busy -> exactly 4 write pairs in push order.
REQ-033 Hold ym_busy=1 for 10 cen ticks with 1 entry queued -> no strobe during those ticks; the ADDR strobe starts on the first cen edge after busy falls.
REQ-034 ym_busy pulses high during WAIT -> ignored; the next write starts as soon as WAIT ends with busy low.
REQ-035 Assert rst_n=0 during DATA with 2 entries queued -> cs_n/wr_n go high asynchronously; after release, count=0, idle=1, and no further writes occur.
REQ-036 Push and pop on the same edge at count=2 -> count stays 2; pointer wrap exercised over 9 consecutive writes with data matching in order.
